// File: rtl/if_prefetch_if.sv
// if_prefetch_if: bundle of the fetch front end's ROM, redirect, ID-stage and
// observer signals.
//   master : the fetch unit (drives rom_ce_o/rom_addr_o and the inst_* outputs)
//   slave  : its surroundings (ROM data, redirect request, ID-stage ready)
// Ports of the bundle:
//   rom_ce_o, rom_addr_o      fetch request to the synchronous ROM
//   rom_data_i                ROM data, one cycle after the request
//   redirect_i, redirect_pc_i flush and restart address
//   inst_valid_o, inst_ready_i, inst_o, inst_pc_o   ID-stage handshake
//   count_o                   queue occupancy
interface if_prefetch_if #(
  parameter int ADDR_W = 32,
  parameter int INST_W = 32,
  parameter int DEPTH  = 4
) ();
  localparam int CW = $clog2(DEPTH + 1);

  logic              rom_ce_o;
  logic [ADDR_W-1:0] rom_addr_o;
  logic [INST_W-1:0] rom_data_i;
  logic              redirect_i;
  logic [ADDR_W-1:0] redirect_pc_i;
  logic              inst_valid_o;
  logic              inst_ready_i;
  logic [INST_W-1:0] inst_o;
  logic [ADDR_W-1:0] inst_pc_o;
  logic [CW-1:0]     count_o;

  modport master (
    output rom_ce_o, rom_addr_o,
    input  rom_data_i,
    input  redirect_i, redirect_pc_i,
    output inst_valid_o,
    input  inst_ready_i,
    output inst_o, inst_pc_o, count_o
  );

  modport slave (
    input  rom_ce_o, rom_addr_o,
    output rom_data_i,
    output redirect_i, redirect_pc_i,
    input  inst_valid_o,
    output inst_ready_i,
    input  inst_o, inst_pc_o, count_o
  );
endinterface

// File: rtl/if_prefetch.sv
// if_prefetch: credit-limited instruction fetch front end. Issues sequential
// fetches to a one-cycle-latency ROM, buffers {pc, inst} responses in a
// DEPTH-entry circular queue and hands them to ID over valid/ready. A redirect
// flushes the queue, drops any arriving response and restarts at a new PC.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  if_prefetch_if.master (ROM request/data, redirect, ID handshake, count_o)
// Optional feature: define IF_PREFETCH_BYPASS_EN to let a response arriving
// into an empty queue drive the ID outputs in the same cycle.
module if_prefetch #(
  parameter int                ADDR_W   = 32,
  parameter int                INST_W   = 32,
  parameter int                DEPTH    = 4,
  parameter int                PC_STEP  = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
  input logic           clk,
  input logic           rst,
  if_prefetch_if.master bus
);
  localparam int              CW      = $clog2(DEPTH + 1);
  localparam int              PW      = $clog2(DEPTH);
  localparam logic [CW:0]     DEPTH_C = (CW + 1)'(DEPTH);
  localparam logic [CW-1:0]   FULL_C  = CW'(DEPTH);
  localparam logic [ADDR_W-1:0] STEP_C = ADDR_W'(PC_STEP);

  logic [ADDR_W-1:0] fpc;
  logic [ADDR_W-1:0] fpc_q;
  logic              req_q;
  logic [ADDR_W-1:0] q_pc   [DEPTH];
  logic [INST_W-1:0] q_inst [DEPTH];
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     wr_ptr;
  logic [CW-1:0]     count;

  logic [CW:0]       credit;
  logic              issue;
  logic              bypass;
  logic              valid;
  logic              pop;
  logic              pop_q;
  logic              push;

`ifdef IF_PREFETCH_BYPASS_EN
  // An arriving response may be handed straight to ID when nothing is queued.
  assign bypass = req_q && !bus.redirect_i && !rst && (count == {CW{1'b0}});
`else
  assign bypass = 1'b0;
`endif

  // Credit check: queued entries plus the in-flight request must leave room.
  always_comb begin
    credit = {1'b0, count} + {{CW{1'b0}}, req_q};
    issue  = !rst && !bus.redirect_i && (credit < DEPTH_C);
  end

  // ID-side handshake, head selection and queue push/pop qualification.
  always_comb begin
    valid = !rst && !bus.redirect_i && ((count != {CW{1'b0}}) || bypass);
    if (bypass) begin
      bus.inst_o    = bus.rom_data_i;
      bus.inst_pc_o = fpc_q;
    end else begin
      bus.inst_o    = q_inst[rd_ptr];
      bus.inst_pc_o = q_pc[rd_ptr];
    end
    pop   = valid && bus.inst_ready_i;
    // A bypassed instruction never entered the queue, so it does not pop it.
    pop_q = pop && !bypass;
    // A bypassed response is queued only when ID did not take it right away.
    push  = req_q && !bus.redirect_i && !(bypass && bus.inst_ready_i);
  end

  assign bus.inst_valid_o = valid;
  assign bus.rom_ce_o     = issue;
  assign bus.rom_addr_o   = fpc;
  assign bus.count_o      = count;

  // Fetch PC, in-flight tracking, queue pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      fpc    <= RESET_PC;
      fpc_q  <= RESET_PC;
      req_q  <= 1'b0;
      rd_ptr <= {PW{1'b0}};
      wr_ptr <= {PW{1'b0}};
      count  <= {CW{1'b0}};
    end else if (bus.redirect_i) begin
      fpc    <= bus.redirect_pc_i;
      req_q  <= 1'b0;
      rd_ptr <= {PW{1'b0}};
      wr_ptr <= {PW{1'b0}};
      count  <= {CW{1'b0}};
    end else begin
      req_q <= issue;
      if (issue) begin
        fpc   <= fpc + STEP_C;
        fpc_q <= fpc;
      end
      // DEPTH is a power of two, so the pointers wrap by overflow.
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop_q) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push, pop_q})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Queue storage; data needs no reset because count gates its visibility.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      q_pc[wr_ptr]   <= fpc_q;
      q_inst[wr_ptr] <= bus.rom_data_i;
    end
  end

  // The credit rule must never let a response arrive into a full queue.
  a_no_push_full: assert property (@(posedge clk) disable iff (rst)
    !(push && (count == FULL_C)));

endmodule

// File: tb/tb_if_prefetch.sv
// tb_if_prefetch: directed, self-checking bench for if_prefetch (default build,
// DEPTH=4, RESET_PC=0). A behavioural ROM answers fetches one cycle later; a
// queue of expected PCs is loaded whenever the stimulus (re)starts the stream
// and each accepted instruction is compared against its head.
module tb_if_prefetch;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  if_prefetch_if #(.ADDR_W(32), .INST_W(32), .DEPTH(DEPTH)) bus ();

  if_prefetch #(
    .ADDR_W(32), .INST_W(32), .DEPTH(DEPTH), .PC_STEP(4), .RESET_PC(32'h0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int          n_assert = 0;
  int          n_fail   = 0;
  int          n_pop    = 0;
  logic [31:0] exp_q[$];

  logic        s_ce, s_valid;
  logic [31:0] s_addr, s_pc, s_inst;
  logic [2:0]  s_count;

  function automatic logic [31:0] romf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // Synchronous ROM model with one-cycle read latency.
  always_ff @(posedge clk) begin
    if (bus.rom_ce_o) bus.rom_data_i <= romf(bus.rom_addr_o);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Load the expected stream starting at pc, discarding anything older.
  task automatic restart(input logic [31:0] pc);
    exp_q.delete();
    for (int i = 0; i < 64; i++) exp_q.push_back(pc + 32'(4 * i));
  endtask

  // Sample outputs mid-cycle, score any accepted instruction, advance a cycle.
  task automatic cycle();
    logic [31:0] e;
    @(negedge clk);
    s_ce    = bus.rom_ce_o;
    s_addr  = bus.rom_addr_o;
    s_valid = bus.inst_valid_o;
    s_pc    = bus.inst_pc_o;
    s_inst  = bus.inst_o;
    s_count = bus.count_o;
    if (s_valid && bus.inst_ready_i) begin
      n_pop++;
      if (exp_q.size() != 0) e = exp_q.pop_front();
      else e = ~s_pc;
      check("sb_pc", s_pc, e);
      check("sb_inst", s_inst, romf(e));
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int p0;
    int nce;
    int found;

    rst = 1'b1;
    bus.redirect_i    = 1'b0;
    bus.redirect_pc_i = 32'h0;
    bus.inst_ready_i  = 1'b1;
    @(posedge clk);
    #1;

    // Reset and in-order delivery
    restart(32'h0);
    repeat (3) cycle();
    check("rst_ce", 32'(s_ce), 32'd0);
    check("rst_valid", 32'(s_valid), 32'd0);
    check("rst_count", 32'(s_count), 32'd0);
    rst = 1'b0;
    cycle(); check("fetch0_ce", 32'(s_ce), 32'd1); check("fetch0_addr", s_addr, 32'h0);
    cycle(); check("fetch1_addr", s_addr, 32'h4);
    cycle(); check("fetch2_addr", s_addr, 32'h8);
             check("first_valid", 32'(s_valid), 32'd1); check("first_pc", s_pc, 32'h0);
    cycle(); check("second_pc", s_pc, 32'h4);
    cycle(); check("third_pc", s_pc, 32'h8);
    p0 = n_pop;
    repeat (8) cycle();
    check("throughput", 32'(n_pop - p0), 32'd8);

    // Backpressure from the first valid
    rst = 1'b1; bus.inst_ready_i = 1'b0; restart(32'h0);
    cycle();
    rst = 1'b0; nce = 0;
    repeat (8) begin cycle(); nce += int'(s_ce); end
    check("bp_fetches", 32'(nce), 32'd4);
    check("bp_count", 32'(s_count), 32'd4);
    check("bp_ce_low", 32'(s_ce), 32'd0);
    bus.inst_ready_i = 1'b1; p0 = n_pop;
    cycle(); check("bp_first_pop_ce", 32'(s_ce), 32'd0); check("bp_first_pc", s_pc, 32'h0);
    cycle(); check("bp_resume_ce", 32'(s_ce), 32'd1); check("bp_resume_addr", s_addr, 32'h10);
    cycle(); cycle();
    check("bp_drain", 32'(n_pop - p0), 32'd4);

    // Redirect while the 0x8 response is arriving
    rst = 1'b1; restart(32'h0);
    cycle();
    rst = 1'b0;
    cycle(); cycle(); cycle();
    bus.redirect_i = 1'b1; bus.redirect_pc_i = 32'h100; restart(32'h100);
    cycle(); check("rd_valid", 32'(s_valid), 32'd0); check("rd_ce", 32'(s_ce), 32'd0);
    bus.redirect_i = 1'b0;
    cycle(); check("rd_count", 32'(s_count), 32'd0); check("rd_fetch", s_addr, 32'h100);
    cycle(); check("rd_fetch2", s_addr, 32'h104);
    cycle(); check("rd_valid3", 32'(s_valid), 32'd1); check("rd_pc", s_pc, 32'h100);
    cycle(); check("rd_pc2", s_pc, 32'h104);

    // Push and pop together around count 3 with ready toggling
    bus.inst_ready_i = 1'b0; found = 0;
    for (int i = 0; i < 20 && found == 0; i++) begin
      cycle();
      if (s_count == 3'd3) found = 1;
    end
    check("reach_count3", 32'(found), 32'd1);
    p0 = n_pop;
    for (int i = 0; i < 32; i++) begin
      bus.inst_ready_i = (i % 2 == 0);
      cycle();
      check("count_bound", 32'(s_count <= 3'd4), 32'd1);
    end
    check("toggle_pops", 32'(n_pop - p0), 32'd16);

    // Fetch address wrap-around
    bus.inst_ready_i = 1'b1;
    bus.redirect_i = 1'b1; bus.redirect_pc_i = 32'hFFFF_FFFC; restart(32'hFFFF_FFFC);
    cycle();
    bus.redirect_i = 1'b0;
    cycle(); check("wrap_fetch0", s_addr, 32'hFFFF_FFFC); check("wrap_ce", 32'(s_ce), 32'd1);
    cycle(); check("wrap_fetch1", s_addr, 32'h0);
    cycle(); check("wrap_pc0", s_pc, 32'hFFFF_FFFC);
    cycle(); check("wrap_pc1", s_pc, 32'h0);

    // Reset with the queue partly full and a request in flight
    bus.inst_ready_i = 1'b0;
    cycle();
    rst = 1'b1; restart(32'h0);
    cycle(); check("mr_pre_count", 32'(s_count), 32'd2);
             check("mr_valid", 32'(s_valid), 32'd0); check("mr_ce", 32'(s_ce), 32'd0);
    rst = 1'b0; bus.inst_ready_i = 1'b1;
    cycle(); check("mr_count", 32'(s_count), 32'd0); check("mr_valid_after", 32'(s_valid), 32'd0);
             check("mr_fetch", s_addr, 32'h0); check("mr_fetch_ce", 32'(s_ce), 32'd1);
    cycle();
    cycle(); check("mr_pc", s_pc, 32'h0);
    repeat (4) cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
